// File: rtl/eth_seq_if.sv
// Host/controller signal bundle for the Ethernet buffer-handshake sequencer.
// slave: the sequencer itself. master: whatever drives the host requests and
// plays the controller side (the bench, or the surrounding host logic).
interface eth_seq_if;
  logic        tx_req;
  logic [10:0] tx_len;
  logic        tx_ack;
  logic        tx_to;
  logic        txrdy;
  logic [10:0] txcntb;
  logic        txdone;
  logic        rxrdy;
  logic [10:0] rxcntb;
  logic        rx_req;
  logic [10:0] rx_len;
  logic        rx_ack;
  logic        rxdone;
  logic [4:0]  cfg;
  logic [4:0]  lbmode;
  logic        cfg_pend;
  logic [7:0]  errs;
  logic [7:0]  err_stat;
  logic        err_clr;

  modport slave (
    input  tx_req, tx_len, txdone, rxrdy, rxcntb, rx_ack, cfg, errs, err_clr,
    output tx_ack, tx_to, txrdy, txcntb, rx_req, rx_len, rxdone, lbmode,
           cfg_pend, err_stat
  );

  modport master (
    output tx_req, tx_len, txdone, rxrdy, rxcntb, rx_ack, cfg, errs, err_clr,
    input  tx_ack, tx_to, txrdy, txcntb, rx_req, rx_len, rxdone, lbmode,
           cfg_pend, err_stat
  );
endinterface

// File: rtl/eth_seq.sv
// Ethernet controller buffer-handshake sequencer: tx ready/done and rx
// ready/done handshakes, 2-flop synchronizers for the controller's async
// signals, tx timeout, sticky error status and quiescent-only lbmode update.

// One async bit into the clk domain.
module eth_seq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // two-flop synchronizer, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module eth_seq #(
  parameter int unsigned     TO_W   = 16,
  parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
  input logic       clk,
  input logic       rst_n,
  eth_seq_if.slave  bus
);
  localparam int unsigned     SYNC_W  = 10;
  localparam logic [TO_W-1:0] TO_LAST = TO_MAX - TO_W'(1);

  typedef enum logic [1:0] {T_IDLE, T_ARM, T_DONE} tx_st_t;
  typedef enum logic [1:0] {R_IDLE, R_HOST, R_DONE} rx_st_t;

  // Synchronized controller signals: bit0 txdone, bit1 rxrdy, bits 9:2 errs.
  logic [SYNC_W-1:0] sync_d, sync_q;
  logic              txdone_s, rxrdy_s;
  logic [7:0]        errs_s;

  assign sync_d   = {bus.errs, bus.rxrdy, bus.txdone};
  assign txdone_s = sync_q[0];
  assign rxrdy_s  = sync_q[1];
  assign errs_s   = sync_q[9:2];

  for (genvar i = 0; i < SYNC_W; i++) begin : g_sync
    eth_seq_sync u_sync (.clk(clk), .rst_n(rst_n), .d(sync_d[i]), .q(sync_q[i]));
  end

  tx_st_t      tx_st, tx_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic        to_flag, to_flag_nx;
  logic        txrdy_q, txrdy_nx;
  logic [10:0] txcntb_q, txcntb_nx;
  logic        tx_ack_q, tx_ack_nx;
  logic        tx_to_q, tx_to_nx;

  rx_st_t      rx_st, rx_nx;
  logic        rx_req_q, rx_req_nx;
  logic [10:0] rx_len_q, rx_len_nx;
  logic        rxdone_q, rxdone_nx;

  logic [4:0]  lbmode_q;
  logic [7:0]  err_stat_q;
  logic        cfg_pend;

  // A requested configuration differing from the applied one blocks new tx.
  assign cfg_pend = (bus.cfg != lbmode_q);

  // tx state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st    <= T_IDLE;
      to_cnt   <= '0;
      to_flag  <= 1'b0;
      txrdy_q  <= 1'b0;
      txcntb_q <= '0;
      tx_ack_q <= 1'b0;
      tx_to_q  <= 1'b0;
    end else begin
      tx_st    <= tx_nx;
      to_cnt   <= to_cnt_nx;
      to_flag  <= to_flag_nx;
      txrdy_q  <= txrdy_nx;
      txcntb_q <= txcntb_nx;
      tx_ack_q <= tx_ack_nx;
      tx_to_q  <= tx_to_nx;
    end
  end

  // tx next state: txdone beats the timeout when both land on one cycle
  always_comb begin
    tx_nx      = tx_st;
    to_cnt_nx  = to_cnt;
    to_flag_nx = to_flag;
    txrdy_nx   = txrdy_q;
    txcntb_nx  = txcntb_q;
    tx_ack_nx  = 1'b0;
    tx_to_nx   = 1'b0;
    case (tx_st)
      T_IDLE: begin
        if (bus.tx_req && !cfg_pend) begin
          txcntb_nx = bus.tx_len;
          txrdy_nx  = 1'b1;
          to_cnt_nx = '0;
          tx_nx     = T_ARM;
        end
      end
      T_ARM: begin
        to_cnt_nx = to_cnt + TO_W'(1);
        if (txdone_s) begin
          txrdy_nx = 1'b0;
          tx_nx    = T_DONE;
        end else if (to_cnt == TO_LAST) begin
          txrdy_nx   = 1'b0;
          to_flag_nx = 1'b1;
          tx_nx      = T_DONE;
        end
      end
      T_DONE: begin
        if (!txdone_s) begin
          tx_ack_nx  = 1'b1;
          tx_to_nx   = to_flag;
          to_flag_nx = 1'b0;
          tx_nx      = T_IDLE;
        end
      end
      default: begin
        txrdy_nx = 1'b0;
        tx_nx    = T_IDLE;
      end
    endcase
  end

  // rx state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= R_IDLE;
      rx_req_q <= 1'b0;
      rx_len_q <= '0;
      rxdone_q <= 1'b0;
    end else begin
      rx_st    <= rx_nx;
      rx_req_q <= rx_req_nx;
      rx_len_q <= rx_len_nx;
      rxdone_q <= rxdone_nx;
    end
  end

  // rx next state: frames accepted only while rx_enable is applied
  always_comb begin
    rx_nx     = rx_st;
    rx_req_nx = rx_req_q;
    rx_len_nx = rx_len_q;
    rxdone_nx = rxdone_q;
    case (rx_st)
      R_IDLE: begin
        if (lbmode_q[0] && rxrdy_s) begin
          rx_len_nx = bus.rxcntb;
          rx_req_nx = 1'b1;
          rx_nx     = R_HOST;
        end
      end
      R_HOST: begin
        if (bus.rx_ack) begin
          rx_req_nx = 1'b0;
          rxdone_nx = 1'b1;
          rx_nx     = R_DONE;
        end
      end
      R_DONE: begin
        if (!rxrdy_s) begin
          rxdone_nx = 1'b0;
          rx_nx     = R_IDLE;
        end
      end
      default: begin
        rx_req_nx = 1'b0;
        rxdone_nx = 1'b0;
        rx_nx     = R_IDLE;
      end
    endcase
  end

  // apply cfg only when both directions are idle and no tx is being requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lbmode_q <= '0;
    else if (tx_st == T_IDLE && rx_st == R_IDLE && !bus.tx_req)
      lbmode_q <= bus.cfg;
  end

  // sticky error flags; clear wins over a same-cycle new error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_stat_q <= '0;
    else
      err_stat_q <= (err_stat_q | errs_s) & ~{8{bus.err_clr}};
  end

  assign bus.tx_ack   = tx_ack_q;
  assign bus.tx_to    = tx_to_q;
  assign bus.txrdy    = txrdy_q;
  assign bus.txcntb   = txcntb_q;
  assign bus.rx_req   = rx_req_q;
  assign bus.rx_len   = rx_len_q;
  assign bus.rxdone   = rxdone_q;
  assign bus.lbmode   = lbmode_q;
  assign bus.cfg_pend = cfg_pend;
  assign bus.err_stat = err_stat_q;
endmodule

// File: tb/tb_eth_seq.sv
// Directed/randomized bench for eth_seq. Expected timing comes from the
// handshake rules: async inputs take 2 clk to synchronize plus 1 clk for the
// registered response, so a controller edge shows up 3 clk later.
module tb_eth_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_seq_if bus ();

  eth_seq #(.TO_W(16), .TO_MAX(16'd16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam int SYNC_LAT = 3;   // controller edge to registered response
  localparam int TO_CYC   = 16;  // txrdy high cycles on timeout

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, h, hi, ack_seen;
    logic [10:0] len;
    logic [7:0] e_hist [0:39];
    logic       c_hist [0:39];
    logic [7:0] exp_stat, e_old;

    bus.tx_req = 0; bus.tx_len = 0; bus.txdone = 0; bus.rxrdy = 0;
    bus.rxcntb = 0; bus.rx_ack = 0; bus.cfg = 0; bus.errs = 0; bus.err_clr = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txrdy", bus.txrdy, 0);   chk("rst_tx_ack", bus.tx_ack, 0);
    chk("rst_tx_to", bus.tx_to, 0);   chk("rst_txcntb", bus.txcntb, 0);
    chk("rst_rx_req", bus.rx_req, 0); chk("rst_rx_len", bus.rx_len, 0);
    chk("rst_rxdone", bus.rxdone, 0); chk("rst_lbmode", bus.lbmode, 0);
    chk("rst_cfg_pend", bus.cfg_pend, 0); chk("rst_err_stat", bus.err_stat, 0);
    rst_n = 1;
    step();

    // config applies while quiescent
    bus.cfg = 5'b00001;
    #1;
    chk("cfg_pend_set", bus.cfg_pend, 1);
    step();
    chk("cfg_apply", bus.lbmode, 5'b00001);
    chk("cfg_pend_clr", bus.cfg_pend, 0);

    // tx frames; third one lands txdone on the timeout cycle (txdone wins)
    for (int f = 0; f < 3; f++) begin
      d   = (f == 0) ? 10 : (f == 1) ? $urandom_range(1, 12) : 13;
      h   = (f == 0) ? 8 : $urandom_range(3, 9);
      len = (f == 0) ? 11'd64 : 11'($urandom_range(1, 2047));
      bus.tx_req = 1; bus.tx_len = len;
      step();
      chk("tx_rise", bus.txrdy, 1);
      chk("tx_cntb", bus.txcntb, len);
      bus.tx_req = 0;
      for (int k = 1; k <= d; k++) begin
        step();
        chk("tx_hold", bus.txrdy, 1);
      end
      bus.txdone = 1;
      for (int k = 1; k <= SYNC_LAT; k++) begin
        step();
        chk("tx_fall", bus.txrdy, (k < SYNC_LAT) ? 1 : 0);
      end
      for (int k = SYNC_LAT; k < h; k++) begin
        step();
        chk("tx_noack", bus.tx_ack, 0);
      end
      bus.txdone = 0;
      for (int k = 1; k <= SYNC_LAT; k++) begin
        step();
        chk("tx_ack", bus.tx_ack, (k == SYNC_LAT) ? 1 : 0);
      end
      chk("tx_to_normal", bus.tx_to, 0);
      step();
      chk("tx_ack_pulse", bus.tx_ack, 0);
    end

    // timeout: txdone never comes
    len = 11'($urandom_range(1, 2047));
    bus.tx_req = 1; bus.tx_len = len;
    step();
    chk("to_cntb", bus.txcntb, len);
    bus.tx_req = 0;
    hi = 0;
    while (bus.txrdy === 1'b1 && hi < 40) begin
      hi++;
      step();
    end
    chk("to_high_cycles", hi, TO_CYC);
    chk("to_ack_early", bus.tx_ack, 0);
    step();
    chk("to_ack", bus.tx_ack, 1);
    chk("to_flag", bus.tx_to, 1);
    step();
    chk("to_ack_pulse", bus.tx_ack, 0);
    chk("to_flag_clr", bus.tx_to, 0);

    // rx ack while idle is ignored
    bus.rx_ack = 1;
    step();
    bus.rx_ack = 0;
    chk("rx_ack_idle", bus.rxdone, 0);

    // rx frames
    for (int f = 0; f < 3; f++) begin
      len = (f == 0) ? 11'd1518 : 11'($urandom_range(0, 2047));
      bus.rxcntb = len; bus.rxrdy = 1;
      for (int k = 1; k <= SYNC_LAT; k++) begin
        step();
        chk("rx_req", bus.rx_req, (k == SYNC_LAT) ? 1 : 0);
      end
      chk("rx_len", bus.rx_len, len);
      repeat ($urandom_range(0, 4)) begin
        step();
        chk("rx_wait", bus.rx_req, 1);
      end
      bus.rx_ack = 1;
      step();
      bus.rx_ack = 0;
      chk("rx_done_set", bus.rxdone, 1);
      chk("rx_req_clr", bus.rx_req, 0);
      bus.rxrdy = 0;
      for (int k = 1; k <= SYNC_LAT; k++) begin
        step();
        chk("rx_done_clr", bus.rxdone, (k < SYNC_LAT) ? 1 : 0);
      end
    end

    // rx disabled
    bus.cfg = 5'b00000;
    step();
    chk("rx_dis_lb", bus.lbmode, 0);
    bus.rxrdy = 1;
    repeat (6) begin
      step();
      chk("rx_dis_req", bus.rx_req, 0);
    end
    bus.rxrdy = 0;
    repeat (3) step();
    bus.cfg = 5'b00001;
    step();
    chk("rx_en_lb", bus.lbmode, 5'b00001);

    // cfg change deferred during an rx frame; blocked tx request
    len = 11'($urandom_range(0, 2047));
    bus.rxcntb = len; bus.rxrdy = 1;
    repeat (SYNC_LAT) step();
    chk("def_rx_req", bus.rx_req, 1);
    bus.cfg = 5'b00011;
    #1;
    chk("def_pend", bus.cfg_pend, 1);
    bus.tx_req = 1; bus.tx_len = 11'd7;
    repeat (4) begin
      step();
      chk("def_txrdy", bus.txrdy, 0);
      chk("def_lb_hold", bus.lbmode, 5'b00001);
    end
    bus.tx_req = 0;
    bus.rx_ack = 1;
    step();
    bus.rx_ack = 0;
    chk("def_rxdone", bus.rxdone, 1);
    bus.rxrdy = 0;
    repeat (SYNC_LAT) begin
      step();
      chk("def_lb_wait", bus.lbmode, 5'b00001);
    end
    chk("def_rxdone_clr", bus.rxdone, 0);
    chk("def_pend_wait", bus.cfg_pend, 1);
    step();
    chk("def_lb_apply", bus.lbmode, 5'b00011);
    chk("def_pend_clr", bus.cfg_pend, 0);
    bus.cfg = 5'b00001;
    step();

    // error pulse, sticky, clear
    bus.errs = 8'h01;
    step();
    bus.errs = 8'h00;
    step();
    chk("err_lat", bus.err_stat, 8'h00);
    step();
    chk("err_set", bus.err_stat, 8'h01);
    repeat (3) begin
      step();
      chk("err_hold", bus.err_stat, 8'h01);
    end
    bus.err_clr = 1;
    step();
    bus.err_clr = 0;
    chk("err_clr", bus.err_stat, 8'h00);

    // clear vs persistent error
    bus.errs = 8'h80;
    repeat (SYNC_LAT) step();
    chk("err_persist", bus.err_stat, 8'h80);
    bus.err_clr = 1;
    step();
    bus.err_clr = 0;
    chk("err_clr_wins", bus.err_stat, 8'h00);
    step();
    chk("err_reset", bus.err_stat, 8'h80);
    bus.errs = 8'h00;
    repeat (2) step();
    bus.err_clr = 1;
    step();
    bus.err_clr = 0;
    step();
    chk("err_quiet", bus.err_stat, 8'h00);

    // random error/clear traffic against a delayed-OR model
    exp_stat = 8'h00;
    for (int n = 0; n < 40; n++) begin
      e_hist[n] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      c_hist[n] = ($urandom_range(0, 5) == 0);
      bus.errs = e_hist[n]; bus.err_clr = c_hist[n];
      step();
      e_old = (n >= 2) ? e_hist[n-2] : 8'h00;
      exp_stat = (exp_stat | e_old) & ~{8{c_hist[n]}};
      chk("err_rand", bus.err_stat, exp_stat);
    end
    bus.errs = 0; bus.err_clr = 0;

    // async reset mid-frame
    bus.tx_req = 1; bus.tx_len = 11'd100;
    step();
    bus.tx_req = 0;
    bus.rxcntb = 11'd60; bus.rxrdy = 1;
    repeat (SYNC_LAT) step();
    bus.rx_ack = 1;
    step();
    bus.rx_ack = 0;
    chk("pre_rst_txrdy", bus.txrdy, 1);
    chk("pre_rst_rxdone", bus.rxdone, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_txrdy", bus.txrdy, 0);
    chk("arst_rxdone", bus.rxdone, 0);
    bus.rxrdy = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    ack_seen = 0;
    repeat (20) begin
      step();
      if (bus.tx_ack === 1'b1) ack_seen++;
    end
    chk("post_rst_noack", ack_seen, 0);
    chk("post_rst_txrdy", bus.txrdy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
